// File: rtl/mul_sequencer_pkg.sv
// Shared types for the iterative multiplier: FSM encoding and ALU-compatible flag layout.
// No logic; no latency or flow control of its own.
package mul_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/mul_datapath.sv
// Shift-add engine: acc/mcand/mplier/count registers updated by load or step, one bit per step.
// Single-cycle step; no flow control of its own, the sequencer decides when to load/step.
module mul_datapath
    import mul_sequencer_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int EARLY_TERM = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             accumulate_i,
    input  logic [WIDTH-1:0] multiplicand_i,
    input  logic [WIDTH-1:0] multiplier_i,
    input  logic [WIDTH-1:0] addend_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             last_o
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mplier_shift;

    assign sum_o        = mplier_q[0] ? acc_q + mcand_q : acc_q;
    assign mplier_shift = mplier_q >> 1;
    // Exit is judged on the current step: it is the final one if the count saturates
    // or no multiplier bits remain after this shift.
    assign last_o = (cnt_q == CW'(WIDTH - 1)) ||
                    ((EARLY_TERM != 0) && (mplier_shift == '0));

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            acc_d    = accumulate_i ? addend_i : '0;
            mcand_d  = multiplicand_i;
            mplier_d = multiplier_i;
            cnt_d    = '0;
        end else if (step_i) begin
            acc_d    = sum_o;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_shift;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/mul_sequencer.sv
// MUL/MLA sequencer: IDLE -> RUN (k cycles) -> DONE, done pulse k+1 cycles after start.
// Holds the pipeline via stall while loading/running; starts while busy are dropped.
module mul_sequencer
    import mul_sequencer_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int EARLY_TERM = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic             accumulate,
    input  logic             setFlags,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    input  logic [WIDTH-1:0] addend,
    input  logic [3:0]       statusIn,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       statusOut
);

    mul_state_t       state_q, state_d;
    logic             busy_q, done_q, setflags_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       status_out_q, status_cap_q, flags_d;
    logic             load, step, last, finish;
    logic [WIDTH-1:0] sum;

    mul_datapath #(
        .WIDTH      (WIDTH),
        .EARLY_TERM (EARLY_TERM)
    ) u_dp (
        .clk            (clk),
        .rst            (rst),
        .load_i         (load),
        .step_i         (step),
        .accumulate_i   (accumulate),
        .multiplicand_i (multiplicand),
        .multiplier_i   (multiplier),
        .addend_i       (addend),
        .sum_o          (sum),
        .last_o         (last)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    step = 1'b1;
                    if (last) state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign finish = (state_q == ST_RUN) && !flush && last;

    always_comb begin
        flags_d = status_cap_q;
        if (setflags_q) begin
            flags_d[FLAG_N] = sum[WIDTH-1];
            flags_d[FLAG_Z] = (sum == '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= '0;
            status_out_q <= '0;
            status_cap_q <= '0;
            setflags_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= finish;
            if (load) begin
                status_cap_q <= statusIn;
                setflags_q   <= setFlags;
            end
            if (finish) begin
                result_q     <= sum;
                status_out_q <= flags_d;
            end
        end
    end

    // Combinational so the load cycle itself holds the upstream stages.
    assign stall = rst && (((state_q == ST_IDLE) && start && !flush) || (state_q == ST_RUN));

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign statusOut = status_out_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: early-terminating and full-width instances share inputs.
module tb_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, flush, accumulate, setFlags;
    logic [31:0] multiplicand, multiplier, addend;
    logic [3:0]  statusIn;

    logic        busy, stall, done;
    logic [31:0] result;
    logic [3:0]  statusOut;
    logic        busy_ne, stall_ne, done_ne;
    logic [31:0] result_ne;
    logic [3:0]  status_ne;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mul_sequencer #(.WIDTH(32), .EARLY_TERM(1)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .accumulate(accumulate), .setFlags(setFlags),
        .multiplicand(multiplicand), .multiplier(multiplier), .addend(addend),
        .statusIn(statusIn), .busy(busy), .stall(stall), .done(done),
        .result(result), .statusOut(statusOut)
    );

    mul_sequencer #(.WIDTH(32), .EARLY_TERM(0)) dut_ne (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .accumulate(accumulate), .setFlags(setFlags),
        .multiplicand(multiplicand), .multiplier(multiplier), .addend(addend),
        .statusIn(statusIn), .busy(busy_ne), .stall(stall_ne), .done(done_ne),
        .result(result_ne), .statusOut(status_ne)
    );

    // Called at a negedge of an IDLE cycle; returns at the negedge of the done cycle.
    // lat counts cycles after the sampling edge, so done in cycle k+1 gives lat = k+1.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          input logic acc, input logic sf, input logic [3:0] st, input bit use_ne,
                          output int lat, output logic [31:0] res, output logic [3:0] so,
                          output logic stall1, output logic busy1, output logic stall_d);
        multiplicand = a; multiplier = b; addend = c;
        accumulate = acc; setFlags = sf; statusIn = st;
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        stall1 = use_ne ? stall_ne : stall;
        busy1  = use_ne ? busy_ne : busy;
        lat = 1;
        while (!(use_ne ? done_ne : done) && lat < 40) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        res     = use_ne ? result_ne : result;
        so      = use_ne ? status_ne : statusOut;
        stall_d = use_ne ? stall_ne : stall;
    endtask

    task automatic test_reset();
        #12;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
        total++; if (statusOut !== 4'h0) begin bad++; $display("FAIL reset_status got=%b exp=0000", statusOut); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_mul_basic();
        int lat; logic [31:0] res; logic [3:0] so; logic s1, b1, sd;
        @(negedge clk);
        run_op(32'd7, 32'd6, 32'd0, 1'b0, 1'b1, 4'b1110, 1'b0, lat, res, so, s1, b1, sd);
        total++; if (lat !== 4) begin bad++; $display("FAIL mul7x6_latency got=%0d exp=4", lat); end
        total++; if (res !== 32'd42) begin bad++; $display("FAIL mul7x6_result got=%0d exp=42", res); end
        total++; if (so !== 4'b0010) begin bad++; $display("FAIL mul7x6_flags got=%b exp=0010", so); end
        total++; if (s1 !== 1'b1 || b1 !== 1'b1) begin bad++; $display("FAIL mul7x6_run_stall_busy got=%b%b exp=11", s1, b1); end
        total++; if (sd !== 1'b0) begin bad++; $display("FAIL mul7x6_done_stall got=%b exp=0", sd); end
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mul7x6_pulse_end got done=%b busy=%b exp 0 0", done, busy); end
    endtask

    task automatic test_mla();
        int lat; logic [31:0] res; logic [3:0] so; logic s1, b1, sd;
        run_op(32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1, 1'b1, 4'b0011, 1'b0, lat, res, so, s1, b1, sd);
        total++; if (lat !== 2) begin bad++; $display("FAIL mla_latency got=%0d exp=2", lat); end
        total++; if (res !== 32'h0) begin bad++; $display("FAIL mla_result got=%h exp=0", res); end
        total++; if (so !== 4'b0111) begin bad++; $display("FAIL mla_flags got=%b exp=0111", so); end
        @(negedge clk);
        run_op(32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1, 1'b0, 4'b1010, 1'b0, lat, res, so, s1, b1, sd);
        total++; if (res !== 32'h0) begin bad++; $display("FAIL mla_nos_result got=%h exp=0", res); end
        total++; if (so !== 4'b1010) begin bad++; $display("FAIL mla_nos_flags got=%b exp=1010", so); end
    endtask

    task automatic test_full_width();
        int lat; logic [31:0] res; logic [3:0] so; logic s1, b1, sd;
        @(negedge clk);
        run_op(32'd3, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 4'b0000, 1'b0, lat, res, so, s1, b1, sd);
        total++; if (lat !== 33) begin bad++; $display("FAIL msb_latency got=%0d exp=33", lat); end
        total++; if (res !== 32'h8000_0000) begin bad++; $display("FAIL msb_result got=%h exp=80000000", res); end
        total++; if (so !== 4'b1000) begin bad++; $display("FAIL msb_flags got=%b exp=1000", so); end
        repeat (40) @(negedge clk);
        run_op(32'd7, 32'd6, 32'd0, 1'b0, 1'b1, 4'b0000, 1'b1, lat, res, so, s1, b1, sd);
        total++; if (lat !== 33) begin bad++; $display("FAIL noearly_latency got=%0d exp=33", lat); end
        total++; if (res !== 32'd42) begin bad++; $display("FAIL noearly_result got=%0d exp=42", res); end
    endtask

    task automatic test_flush();
        bit seen;
        @(negedge clk);
        multiplicand = 32'd5; multiplier = 32'h0000_FFFF; accumulate = 1'b0; setFlags = 1'b1;
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        flush = 1'b1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL flush_run_stall got=%b exp=1", stall); end
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        total++; if (busy !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL flush_idle got busy=%b stall=%b exp 0 0", busy, stall); end
        total++; if (result !== 32'd42) begin bad++; $display("FAIL flush_result_kept got=%0d exp=42", result); end
        seen = 1'b0;
        repeat (20) begin @(negedge clk); if (done) seen = 1'b1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_no_done got=%b exp=0", seen); end
        start = 1'b1; flush = 1'b1;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL startflush_stall got=%b exp=0", stall); end
        @(posedge clk); @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL startflush_busy got=%b exp=0", busy); end
        start = 1'b0; flush = 1'b0;
    endtask

    task automatic test_start_ignored();
        int lat;
        @(negedge clk);
        multiplicand = 32'd9; multiplier = 32'h0000_0100; accumulate = 1'b0; setFlags = 1'b0;
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            if (lat == 3) begin
                start = 1'b1; multiplicand = 32'd3; multiplier = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); @(negedge clk);
            lat++;
        end
        start = 1'b0;
        total++; if (lat !== 10) begin bad++; $display("FAIL ignore_latency got=%0d exp=10", lat); end
        total++; if (result !== 32'h900) begin bad++; $display("FAIL ignore_result got=%h exp=900", result); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_no_queue got busy=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] res; logic [3:0] so; logic s1, b1, sd;
        run_op(32'd10, 32'd10, 32'd0, 1'b0, 1'b0, 4'b0000, 1'b0, lat, res, so, s1, b1, sd);
        total++; if (lat !== 5) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=5", lat); end
        total++; if (res !== 32'd100) begin bad++; $display("FAIL b2b_first_result got=%0d exp=100", res); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_pulse got=%b exp=0", done); end
        run_op(32'h1234_5678, 32'd0, 32'h55, 1'b1, 1'b1, 4'b0000, 1'b0, lat, res, so, s1, b1, sd);
        total++; if (lat !== 2) begin bad++; $display("FAIL b2b_second_latency got=%0d exp=2", lat); end
        total++; if (res !== 32'h55) begin bad++; $display("FAIL b2b_second_result got=%h exp=55", res); end
        total++; if (so !== 4'b0000) begin bad++; $display("FAIL b2b_second_flags got=%b exp=0000", so); end
    endtask

    task automatic test_reset_mid_run();
        int lat; logic [31:0] res; logic [3:0] so; logic s1, b1, sd;
        @(negedge clk);
        multiplicand = 32'd2; multiplier = 32'h0000_F000; accumulate = 1'b0; setFlags = 1'b1;
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        #2 rst = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL arst_ctrl got busy=%b stall=%b done=%b exp 0 0 0", busy, stall, done); end
        total++; if (result !== 32'h0 || statusOut !== 4'h0) begin bad++; $display("FAIL arst_data got result=%h status=%b exp 0", result, statusOut); end
        @(negedge clk);
        rst = 1'b1;
        run_op(32'd2, 32'd2, 32'd0, 1'b0, 1'b0, 4'b0000, 1'b0, lat, res, so, s1, b1, sd);
        total++; if (lat !== 3) begin bad++; $display("FAIL arst_after_latency got=%0d exp=3", lat); end
        total++; if (res !== 32'd4) begin bad++; $display("FAIL arst_after_result got=%0d exp=4", res); end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; flush = 1'b0; accumulate = 1'b0; setFlags = 1'b0;
        multiplicand = '0; multiplier = '0; addend = '0; statusIn = '0;
        test_reset();
        test_mul_basic();
        test_mla();
        test_full_width();
        test_flush();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle integer multiply unit and its sequencer for the execution stage: implements ARM MUL/MLA (low 32 bits of Rm×Rs, optionally +Rn) with an iterative shift-add datapath instead of a single-cycle array multiplier. Sits beside the ALU in the execution stage. Stalls the pipeline while iterating, then returns the result and updated NZCV flags for one cycle. Accepts a flush from branch resolution that aborts an in-flight multiply.

## Interface
- WIDTH, 32, operand/result width
- EARLY_TERM, 1, 1 = stop when remaining multiplier bits are all zero; 0 = always WIDTH iterations

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  multiply request from execution stage; sampled only in IDLE
- flush  in  1  abort current operation (branch taken)
- accumulate  in  1  1 = MLA (add addend), 0 = MUL
- setFlags  in  1  instruction S bit
- multiplicand  in  WIDTH  valRm
- multiplier  in  WIDTH  valRs
- addend  in  WIDTH  valRn
- statusIn  in  4  current {N,Z,C,V}
- busy  out  1  registered; high in RUN and DONE
- stall  out  1  freeze upstream stages
- done  out  1  one-cycle pulse; result/statusOut valid
- result  out  WIDTH  product (mod 2^WIDTH); held until next accepted start
- statusOut  out  4  {N,Z,C,V} for the multiply

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1, flush=0: load acc = accumulate ? addend : 0; mcand = multiplicand; mplier = multiplier; count = 0; capture statusIn, setFlags → RUN.
- RUN, each cycle: if mplier[0], acc += mcand (mod 2^WIDTH); mcand <<= 1 (MSB dropped); mplier >>= 1; count++.
- RUN exit → DONE when count == WIDTH-1, or (EARLY_TERM and shifted mplier == 0). At least one RUN cycle always occurs, including multiplier = 0.
- DONE: result = acc; done = 1; → IDLE.
- Flags when setFlags: N = result[WIDTH-1], Z = (result == 0), C and V = captured statusIn[1], statusIn[0]. When setFlags = 0: statusOut = captured statusIn unchanged.
- stall = (IDLE & start & ~flush) | RUN. Low in DONE so the pipeline advances in the same cycle it consumes result.
- start while busy: ignored, no queuing.
- flush: in RUN or DONE → IDLE at next edge, done not asserted, result/statusOut retain previous values. In IDLE, flush overrides start (no load, stall low).
- rst low (any state, including mid-RUN): immediately IDLE; busy, done, result, statusOut, stall = 0; internal acc/mcand/mplier/count = 0.

## Timing
- Start sampled at edge E0. RUN occupies cycles 1..k, DONE is cycle k+1.
- k = WIDTH when EARLY_TERM = 0.
- k = max(1, index of highest set multiplier bit + 1) when EARLY_TERM = 1.
- Latency start → done = k+1 cycles; minimum 2, maximum WIDTH+1.
- done is a single-cycle pulse. Back-to-back start is accepted in the IDLE cycle immediately after DONE.
- All outputs except stall are registered.

## Structure
- Shared package/header: state encoding (IDLE, RUN, DONE) and flag indices N=3, Z=2, C=1, V=0, matching the ALU status layout.
- One sub-module, mul_datapath: acc/mcand/mplier/count registers and the adder, with load/step controls. mul_sequencer holds the FSM, flag logic and output registers.
- count width = clog2(WIDTH).

## Test plan
- 7×6, MUL, setFlags=1, EARLY_TERM=1 → 3 RUN cycles, done in cycle 4, result 42, N=0 Z=0, C/V equal statusIn.
- MLA 0xFFFFFFFF×1 + 1 → 1 RUN cycle, result 0, Z=1 N=0; with setFlags=0, statusOut = statusIn.
- 3×0x80000000 → 32 RUN cycles, result 0x80000000, N=1. With EARLY_TERM=0, 7×6 also takes 32 RUN cycles, result still 42.
- Flush at RUN cycle 5 → no done pulse, busy/stall low next cycle, result keeps the prior 42. Start+flush together in IDLE → stays IDLE, stall 0.
- Start pulsed during RUN with new operands → ignored; the original product completes unchanged.
- rst driven low mid-RUN (asynchronous, between edges) → busy, stall, done, result, statusOut = 0 immediately. After release, a new 2×2 returns 4.
